uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx.sv | 122 ++++++++++++
 tb/tb_uart_rx.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line in, received byte and status strobes out.
interface uart_rx_if;
    logic       pin;
    logic [7:0] byte_received;
    logic       valid;
    logic       framing_error;
    logic       busy;
    modport master (output pin, input byte_received, valid, framing_error, busy);
    modport slave  (input pin, output byte_received, valid, framing_error, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, LSB first, one-cycle valid / framing_error strobes.
// Define UART_RX_MAJORITY_EN to decide each bit on a 2-of-3 vote of recent samples.
module uart_rx #(
    parameter int clocks_per_bit = 1
) (
    input logic       clock,
    input logic       reset,
    uart_rx_if.slave  bus
);
    localparam int CW = $clog2(clocks_per_bit) + 1;
    localparam logic [CW-1:0] HALF_C = CW'((clocks_per_bit - 1) / 2);
    localparam logic [CW-1:0] LAST_C = CW'(clocks_per_bit - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] clocks_q;
    logic [2:0]    bit_index_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;
    logic          busy_q;
    logic          rx_s;
    logic          sample;

    assign rx_s = sync_q[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.pin};
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote over rx_s and its two predecessors, so the centre sits one clock earlier.
    logic [1:0] hist_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) hist_q <= 2'b11;
        else       hist_q <= {hist_q[0], rx_s};
    end
    assign sample = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clocks_q    <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q  <= START;
                        clocks_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (clocks_q == HALF_C) begin
                        clocks_q    <= '0;
                        bit_index_q <= '0;
                        state_q     <= sample ? IDLE : DATA;
                        busy_q      <= !sample;
                    end else begin
                        clocks_q <= clocks_q + 1'b1;
                    end
                end
                DATA: begin
                    if (clocks_q == LAST_C) begin
                        shift_q[bit_index_q] <= sample;
                        clocks_q             <= '0;
                        bit_index_q          <= bit_index_q + 3'd1;
                        if (bit_index_q == 3'd7) state_q <= STOP;
                    end else begin
                        clocks_q <= clocks_q + 1'b1;
                    end
                end
                STOP: begin
                    if (clocks_q == LAST_C) begin
                        clocks_q <= '0;
                        if (sample) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        clocks_q <= clocks_q + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_received = byte_q;
    assign bus.valid         = valid_q;
    assign bus.framing_error = ferr_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames checked each cycle against an event-queue model.
module tb_uart_rx;
    localparam int CPB = 4;
    localparam int LAT = 41;

    typedef struct {int t; bit good; logic [7:0] b;} ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   fcount = 0;
    int   t0;
    ev_t  evq[$];
    int   vcyc[$];
    int   vbyte[$];
    logic [7:0] model_byte = 8'h00;
    logic exp_v, exp_f;

    uart_rx_if bus();
    uart_rx #(.clocks_per_bit(CPB)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // A frame whose start bit is driven after edge k completes at edge k+41.
    task automatic send(input logic [7:0] b, input logic stop, input int gl);
        logic [9:0] f;
        ev_t e;
        f = {stop, b, 1'b0};
        e.t = cyc + LAT;
        e.good = stop;
        e.b = b;
        evq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            bus.pin = f[i];
            if (i == gl) begin
                @(negedge clock);
                bus.pin = ~f[i];
                @(negedge clock);
                bus.pin = f[i];
                repeat (CPB - 2) @(negedge clock);
            end else begin
                repeat (CPB) @(negedge clock);
            end
        end
    endtask

    always @(negedge clock) begin
        #1;
        if (reset) begin
            evq.delete();
            model_byte = 8'h00;
        end
        exp_v = 1'b0;
        exp_f = 1'b0;
        if (evq.size() > 0 && evq[0].t == cyc) begin
            exp_v = evq[0].good;
            exp_f = !evq[0].good;
            if (evq[0].good) model_byte = evq[0].b;
            void'(evq.pop_front());
        end
        chk("valid", int'(bus.valid), int'(exp_v));
        chk("framing_error", int'(bus.framing_error), int'(exp_f));
        chk("byte_received", int'(bus.byte_received), int'(model_byte));
        chk("valid_and_ferr", int'(bus.valid & bus.framing_error), 0);
        if (bus.valid) begin
            vcyc.push_back(cyc);
            vbyte.push_back(int'(bus.byte_received));
        end
        if (bus.framing_error) fcount++;
    end

    initial begin
        bus.pin = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_byte", int'(bus.byte_received), 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("idle_busy", int'(bus.busy), 0);
        end

        t0 = cyc;
        send(8'hA5, 1'b1, -1);
        chk("a5_busy_in_stop", int'(bus.busy), 1);
        repeat (3) @(negedge clock);
        chk("a5_count", vcyc.size(), 1);
        chk("a5_edge", vcyc[0] - (t0 + 1), 40);
        chk("a5_byte", vbyte[0], 8'hA5);
        chk("a5_busy_after", int'(bus.busy), 0);

        send(8'h00, 1'b1, -1);
        send(8'hFF, 1'b1, -1);
        repeat (3) @(negedge clock);
        chk("b2b_count", vcyc.size(), 3);
        chk("b2b_gap", vcyc[2] - vcyc[1], 40);
        chk("b2b_first", vbyte[1], 8'h00);
        chk("b2b_second", vbyte[2], 8'hFF);

        send(8'h3C, 1'b0, -1);
        repeat (50 * CPB) @(negedge clock);
        chk("break_busy", int'(bus.busy), 1);
        bus.pin = 1'b1;
        repeat (20) @(negedge clock);
        chk("fe_count", fcount, 1);
        chk("fe_no_valid", vcyc.size(), 3);
        chk("fe_byte_kept", int'(bus.byte_received), 8'hFF);
        chk("fe_busy_after", int'(bus.busy), 0);

        bus.pin = 1'b0;
        @(negedge clock);
        bus.pin = 1'b1;
        repeat (2) @(negedge clock);
        chk("glitch_start", int'(bus.busy), 1);
        repeat (6) @(negedge clock);
        chk("glitch_idle", int'(bus.busy), 0);
        chk("glitch_no_valid", vcyc.size(), 3);
        chk("glitch_no_fe", fcount, 1);
`ifdef UART_RX_MAJORITY_EN
        send(8'h00, 1'b1, 4);
        repeat (3) @(negedge clock);
        chk("maj_count", vcyc.size(), 4);
        chk("maj_byte", int'(bus.byte_received), 8'h00);
`endif

        begin
            logic [9:0] f;
            f = {1'b1, 8'h96, 1'b0};
            for (int i = 0; i < 5; i++) begin
                bus.pin = f[i];
                repeat (CPB) @(negedge clock);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_byte", int'(bus.byte_received), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        bus.pin = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        chk("post_rst_byte", int'(bus.byte_received), 0);
        t0 = vcyc.size();
        send(8'h5A, 1'b1, -1);
        repeat (3) @(negedge clock);
        chk("post_rst_count", vcyc.size() - t0, 1);
        chk("post_rst_value", vbyte[vbyte.size() - 1], 8'h5A);
        repeat (5) @(negedge clock);
        chk("pending_events", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
